// File: rtl/oam_dma_arbiter_pkg.sv
// oam_dma_arbiter_pkg: shared state encoding and bus constants for the OAM DMA arbiter
package oam_dma_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_START, S_READ, S_WRITE} dma_state_t;
  localparam int          DEF_DMA_LEN  = 160;
  localparam logic [7:0]  OAM_PAGE     = 8'hFE;
  localparam logic [15:0] DEF_REG_ADDR = 16'hFF46;
  localparam logic [7:0]  OPEN_BUS     = 8'hFF;
endpackage

// File: rtl/oam_dma_arbiter_if.sv
// oam_dma_arbiter_if: CPU-side and memory-side bus bundle around the OAM DMA arbiter
interface oam_dma_arbiter_if;
  logic        cpu_WE;
  logic        cpu_RE;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        mem_WE;
  logic        mem_RE;
  logic [15:0] mem_address;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        dma_active;
  modport master (
    output cpu_WE, cpu_RE, cpu_address, cpu_wdata, mem_rdata,
    input  cpu_rdata, mem_WE, mem_RE, mem_address, mem_wdata, dma_active
  );
  modport slave (
    input  cpu_WE, cpu_RE, cpu_address, cpu_wdata, mem_rdata,
    output cpu_rdata, mem_WE, mem_RE, mem_address, mem_wdata, dma_active
  );
endinterface

// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: muxes the memory bus between the CPU and a page-to-OAM DMA engine
module oam_dma_arbiter import oam_dma_arbiter_pkg::*; #(
  parameter int          DMA_LEN      = DEF_DMA_LEN,
  parameter logic [7:0]  DMA_DST_PAGE = OAM_PAGE,
  parameter logic [15:0] DMA_REG_ADDR = DEF_REG_ADDR
) (
  input logic clk,
  input logic rst,
  oam_dma_arbiter_if.slave bus
);
  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);
  dma_state_t r_state, w_state_nx;
  logic [7:0] r_idx, r_buf, r_src_page;
  logic [7:0] w_idx_nx, w_buf_nx, w_src_nx;
  logic       w_reg_hit, w_reg_wr, w_reg_rd, w_cpu_any, w_last;
  assign w_reg_hit  = bus.cpu_address == DMA_REG_ADDR;
  assign w_reg_wr   = bus.cpu_WE && w_reg_hit;
  assign w_reg_rd   = bus.cpu_RE && !bus.cpu_WE && w_reg_hit;
  assign w_cpu_any  = bus.cpu_WE || bus.cpu_RE;
  assign w_last     = r_idx == LAST_IDX;
  assign bus.dma_active = r_state != S_IDLE;
  assign bus.cpu_rdata  = w_reg_rd ? r_src_page : (r_state == S_IDLE) ? bus.mem_rdata : OPEN_BUS;
  // state, transfer index, captured byte and source page share one reset domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_idx      <= 8'h00;
      r_buf      <= 8'h00;
      r_src_page <= 8'h00;
    end else begin
      r_state    <= w_state_nx;
      r_idx      <= w_idx_nx;
      r_buf      <= w_buf_nx;
      r_src_page <= w_src_nx;
    end
  end
  // next state and bus ownership; a register write overrides whatever the DMA was about to do next
  always_comb begin
    w_state_nx      = r_state;
    w_idx_nx        = r_idx;
    w_buf_nx        = r_buf;
    w_src_nx        = r_src_page;
    bus.mem_WE      = 1'b0;
    bus.mem_RE      = 1'b0;
    bus.mem_address = 16'h0000;
    bus.mem_wdata   = 8'h00;
    case (r_state)
      S_IDLE: if (w_cpu_any && !w_reg_hit) begin
        bus.mem_WE      = bus.cpu_WE;
        bus.mem_RE      = !bus.cpu_WE;
        bus.mem_address = bus.cpu_address;
        bus.mem_wdata   = bus.cpu_wdata;
      end
      S_START: w_state_nx = S_READ;
      S_READ: begin
        bus.mem_RE      = 1'b1;
        bus.mem_address = {r_src_page, r_idx};
        w_buf_nx        = bus.mem_rdata;
        w_state_nx      = S_WRITE;
      end
      S_WRITE: begin
        bus.mem_WE      = 1'b1;
        bus.mem_address = {DMA_DST_PAGE, r_idx};
        bus.mem_wdata   = r_buf;
        w_state_nx      = w_last ? S_IDLE : S_READ;
        w_idx_nx        = w_last ? r_idx : r_idx + 8'd1;
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (w_reg_wr) begin
      w_src_nx   = bus.cpu_wdata;
      w_idx_nx   = 8'h00;
      w_state_nx = S_START;
    end
  end
endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb_oam_dma_arbiter: randomized scenario bench for the OAM DMA arbiter against a memory-image model
module tb_oam_dma_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  oam_dma_arbiter_if bus();
  oam_dma_arbiter_if bus1();
  oam_dma_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  oam_dma_arbiter #(.DMA_LEN(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [7:0] mem     [65536];
  logic [7:0] mem1    [65536];
  logic [7:0] ref_mem [65536];
  assign bus.mem_rdata  = bus.mem_RE  ? mem[bus.mem_address]   : 8'h00;
  assign bus1.mem_rdata = bus1.mem_RE ? mem1[bus1.mem_address] : 8'h00;

  int n_tests = 0;
  int n_fail  = 0;
  logic        s_we, s_re, s_act;
  logic [15:0] s_addr;
  logic [7:0]  s_wd, s_rd;

  // one CPU bus cycle: drive, sample mid-cycle, let memory absorb a write at the edge
  task automatic cyc(input logic we, input logic re, input logic [15:0] a, input logic [7:0] d);
    bus.cpu_WE = we; bus.cpu_RE = re; bus.cpu_address = a; bus.cpu_wdata = d;
    @(negedge clk);
    s_we = bus.mem_WE; s_re = bus.mem_RE; s_act = bus.dma_active;
    s_addr = bus.mem_address; s_wd = bus.mem_wdata; s_rd = bus.cpu_rdata;
    @(posedge clk);
    if (s_we) mem[s_addr] = s_wd;
    #1;
    bus.cpu_WE = 1'b0; bus.cpu_RE = 1'b0; bus.cpu_address = 16'h0000; bus.cpu_wdata = 8'h00;
  endtask

  task automatic fill(input logic [7:0] pg, input bit rnd);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = rnd ? 8'($urandom) : (8'(i) ^ 8'h5A);
      mem[{pg, 8'(i)}] = v;
      ref_mem[{pg, 8'(i)}] = v;
    end
  endtask

  task automatic model_dma(input logic [7:0] pg, input int len);
    for (int i = 0; i < len; i++) ref_mem[{8'hFE, 8'(i)}] = ref_mem[{pg, 8'(i)}];
  endtask

  function automatic int mem_diffs();
    int c = 0;
    for (int a = 0; a < 65536; a++) if (mem[a] !== ref_mem[a]) c++;
    return c;
  endfunction

  task automatic run_out(inout int n);
    do begin
      cyc(1'b0, 1'b0, 16'h0000, 8'h00);
      n += int'(s_act);
    end while (s_act && n < 400);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({bus.dma_active, bus.mem_WE, bus.mem_RE} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl: got %b want 000", {bus.dma_active, bus.mem_WE, bus.mem_RE}); end
    n_tests++;
    if ({bus.mem_address, bus.mem_wdata} !== 24'h0) begin n_fail++; $display("FAIL reset_bus: got %h want 000000", {bus.mem_address, bus.mem_wdata}); end
    bus.cpu_RE = 1'b1; bus.cpu_address = 16'hFF46;
    #1;
    n_tests++;
    if ({bus.cpu_rdata, bus.mem_RE} !== 9'h000) begin n_fail++; $display("FAIL reset_reg: got %h want 000", {bus.cpu_rdata, bus.mem_RE}); end
    bus.cpu_RE = 1'b0; bus.cpu_address = 16'h0000;
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(1'b0, 1'b1, 16'hFF46, 8'h00);
    n_tests++;
    if ({s_rd, s_re, s_act} !== 10'h000) begin n_fail++; $display("FAIL reset_release: got %h want 000", {s_rd, s_re, s_act}); end
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 14; i++) begin
      logic we, re;
      logic [15:0] a;
      logic [7:0] d, exp_rd;
      logic [41:0] exp_v;
      we = (i == 1) ? 1'b1 : (i == 0) ? 1'b0 : 1'($urandom);
      re = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : 1'($urandom);
      a  = (i < 2) ? 16'hC123 : 16'($urandom);
      if (a == 16'hFF46) a = 16'hFF45;
      d  = (i == 1) ? 8'hA5 : 8'($urandom);
      exp_rd = ref_mem[a];
      cyc(we, re, a, d);
      exp_v = {1'b0, we, re & ~we, (we | re) ? a : 16'h0000, (we | re) ? d : 8'h00, 8'h00};
      n_tests++;
      if ({s_act, s_we, s_re, s_addr, s_wd, 8'h00} !== exp_v) begin n_fail++; $display("FAIL pass_bus[%0d]: got %h want %h", i, {s_act, s_we, s_re, s_addr, s_wd}, exp_v[41:8]); end
      if (re && !we) begin
        n_tests++;
        if (s_rd !== exp_rd) begin n_fail++; $display("FAIL pass_rdata[%0d]: got %h want %h", i, s_rd, exp_rd); end
      end
      if (we) ref_mem[a] = d;
    end
  endtask

  task automatic test_transfer();
    int n;
    fill(8'hC0, 1'b0);
    cyc(1'b1, 1'b1, 16'hFF46, 8'hC0);
    n_tests++;
    if ({s_we, s_re} !== 2'b00) begin n_fail++; $display("FAIL xfer_regwr_strobes: got %b want 00", {s_we, s_re}); end
    cyc(1'b0, 1'b0, 16'h0000, 8'h00);
    n_tests++;
    if ({s_act, s_we, s_re, s_addr} !== {3'b100, 16'h0000}) begin n_fail++; $display("FAIL xfer_start: got %h want %h", {s_act, s_we, s_re, s_addr}, {3'b100, 16'h0000}); end
    cyc(1'b0, 1'b1, 16'hC000, 8'h00);
    n_tests++;
    if (s_rd !== 8'hFF) begin n_fail++; $display("FAIL xfer_cpu_read_blocked: got %h want ff", s_rd); end
    n_tests++;
    if ({s_re, s_we, s_addr} !== {2'b10, 16'hC000}) begin n_fail++; $display("FAIL xfer_read0: got %h want %h", {s_re, s_we, s_addr}, {2'b10, 16'hC000}); end
    cyc(1'b1, 1'b0, 16'hC001, 8'h12);
    n_tests++;
    if ({s_we, s_re, s_addr, s_wd} !== {2'b10, 16'hFE00, 8'h5A}) begin n_fail++; $display("FAIL xfer_write0: got %h want %h", {s_we, s_re, s_addr, s_wd}, {2'b10, 16'hFE00, 8'h5A}); end
    cyc(1'b0, 1'b1, 16'hFF46, 8'h00);
    n_tests++;
    if (s_rd !== 8'hC0) begin n_fail++; $display("FAIL xfer_reg_read: got %h want c0", s_rd); end
    n = 4;
    run_out(n);
    n_tests++;
    if (n !== 321) begin n_fail++; $display("FAIL xfer_latency: got %0d want 321", n); end
    model_dma(8'hC0, 160);
    n_tests++;
    if (mem_diffs() !== 0) begin n_fail++; $display("FAIL xfer_memory: got %0d bad bytes want 0", mem_diffs()); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      logic [7:0] pg;
      int n;
      pg = 8'($urandom_range(128, 191));
      fill(pg, 1'b1);
      model_dma(pg, 160);
      cyc(1'b1, 1'b0, 16'hFF46, pg);
      n = 0;
      do begin
        int op;
        logic [15:0] a;
        logic [7:0] d;
        op = $urandom_range(0, 3);
        a = 16'($urandom);
        if (a == 16'hFF46) a = 16'hFF45;
        d = 8'($urandom);
        case (op)
          0: cyc(1'b0, 1'b0, 16'h0000, 8'h00);
          1: cyc(1'b0, 1'b1, a, 8'h00);
          2: cyc(1'b1, 1'b0, a, d);
          default: cyc(1'b0, 1'b1, 16'hFF46, 8'h00);
        endcase
        n += int'(s_act);
        if (s_act && op == 1) begin
          n_tests++;
          if (s_rd !== 8'hFF) begin n_fail++; $display("FAIL rnd_open_bus[%0d]: got %h want ff at %h", it, s_rd, a); end
        end
        if (op == 3) begin
          n_tests++;
          if (s_rd !== pg) begin n_fail++; $display("FAIL rnd_reg_read[%0d]: got %h want %h", it, s_rd, pg); end
        end
        if (!s_act && op == 2) ref_mem[a] = d;
      end while (s_act && n < 400);
      n_tests++;
      if (n !== 321) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d want 321", it, n); end
      n_tests++;
      if (mem_diffs() !== 0) begin n_fail++; $display("FAIL rnd_memory[%0d]: got %0d bad bytes want 0", it, mem_diffs()); end
    end
  endtask

  task automatic test_restart();
    int n;
    fill(8'hD0, 1'b1);
    cyc(1'b1, 1'b0, 16'hFF46, 8'hC0);
    repeat (101) cyc(1'b0, 1'b0, 16'h0000, 8'h00);
    cyc(1'b1, 1'b0, 16'hFF46, 8'hD0);
    n_tests++;
    if ({s_re, s_we, s_addr} !== {2'b10, 16'hC032}) begin n_fail++; $display("FAIL restart_at_idx50: got %h want %h", {s_re, s_we, s_addr}, {2'b10, 16'hC032}); end
    cyc(1'b0, 1'b0, 16'h0000, 8'h00);
    n_tests++;
    if ({s_act, s_re, s_we} !== 3'b100) begin n_fail++; $display("FAIL restart_start: got %b want 100", {s_act, s_re, s_we}); end
    n = 1;
    run_out(n);
    n_tests++;
    if (n !== 321) begin n_fail++; $display("FAIL restart_latency: got %0d want 321", n); end
    model_dma(8'hD0, 160);
    n_tests++;
    if (mem_diffs() !== 0) begin n_fail++; $display("FAIL restart_memory: got %0d bad bytes want 0", mem_diffs()); end
  endtask

  task automatic test_reset_mid();
    int n_we, n_act;
    logic [7:0] exp_rd;
    cyc(1'b1, 1'b0, 16'hFF46, 8'hC0);
    repeat (21) cyc(1'b0, 1'b0, 16'h0000, 8'h00);
    n_tests++;
    if ({bus.mem_RE, bus.mem_address} !== {1'b1, 16'hC00A}) begin n_fail++; $display("FAIL rstmid_pre: got %h want %h", {bus.mem_RE, bus.mem_address}, {1'b1, 16'hC00A}); end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({bus.dma_active, bus.mem_RE, bus.mem_WE, bus.mem_address} !== 19'h0) begin n_fail++; $display("FAIL rstmid_abort: got %h want 0", {bus.dma_active, bus.mem_RE, bus.mem_WE, bus.mem_address}); end
    bus.cpu_RE = 1'b1; bus.cpu_address = 16'hFF46;
    #1;
    n_tests++;
    if (bus.cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL rstmid_src_page: got %h want 00", bus.cpu_rdata); end
    bus.cpu_RE = 1'b0; bus.cpu_address = 16'h0000;
    @(posedge clk); #1;
    rst = 1'b1;
    n_we = 0; n_act = 0;
    repeat (10) begin
      cyc(1'b0, 1'b0, 16'h0000, 8'h00);
      n_we += int'(s_we);
      n_act += int'(s_act);
    end
    n_tests++;
    if (n_we !== 0) begin n_fail++; $display("FAIL rstmid_no_write: got %0d want 0", n_we); end
    n_tests++;
    if (n_act !== 0) begin n_fail++; $display("FAIL rstmid_inactive: got %0d want 0", n_act); end
    exp_rd = ref_mem[16'hC123];
    cyc(1'b0, 1'b1, 16'hC123, 8'h00);
    n_tests++;
    if ({s_re, s_addr, s_rd} !== {1'b1, 16'hC123, exp_rd}) begin n_fail++; $display("FAIL rstmid_passthrough: got %h want %h", {s_re, s_addr, s_rd}, {1'b1, 16'hC123, exp_rd}); end
    model_dma(8'hC0, 10);
    n_tests++;
    if (mem_diffs() !== 0) begin n_fail++; $display("FAIL rstmid_memory: got %0d bad bytes want 0", mem_diffs()); end
  endtask

  task automatic test_len1();
    logic [7:0] v;
    logic [41:0] exp_seq [4];
    logic [41:0] got;
    v = 8'($urandom) | 8'h01;
    mem1[16'h8000] = v;
    mem1[16'hFE00] = 8'h00;
    exp_seq[0] = {3'b100, 16'h0000, 8'h00, 15'h0};
    exp_seq[1] = {3'b110, 16'h8000, 8'h00, 15'h0};
    exp_seq[2] = {3'b101, 16'hFE00, v, 15'h0};
    exp_seq[3] = {3'b000, 16'h0000, 8'h00, 15'h0};
    bus1.cpu_WE = 1'b1; bus1.cpu_address = 16'hFF46; bus1.cpu_wdata = 8'h80;
    @(negedge clk);
    @(posedge clk); #1;
    bus1.cpu_WE = 1'b0; bus1.cpu_address = 16'h0000; bus1.cpu_wdata = 8'h00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      got = {bus1.dma_active, bus1.mem_RE, bus1.mem_WE, bus1.mem_address, bus1.mem_wdata, 15'h0};
      @(posedge clk);
      if (bus1.mem_WE) mem1[bus1.mem_address] = bus1.mem_wdata;
      #1;
      n_tests++;
      if (got !== exp_seq[k]) begin n_fail++; $display("FAIL len1_cycle[%0d]: got %h want %h", k, got[41:15], exp_seq[k][41:15]); end
    end
    n_tests++;
    if (mem1[16'hFE00] !== v) begin n_fail++; $display("FAIL len1_oam: got %h want %h", mem1[16'hFE00], v); end
  endtask

  initial begin
    bus.cpu_WE = 1'b0; bus.cpu_RE = 1'b0; bus.cpu_address = 16'h0000; bus.cpu_wdata = 8'h00;
    bus1.cpu_WE = 1'b0; bus1.cpu_RE = 1'b0; bus1.cpu_address = 16'h0000; bus1.cpu_wdata = 8'h00;
    for (int a = 0; a < 65536; a++) begin
      mem[a] = 8'(a) ^ 8'(a >> 8);
      ref_mem[a] = 8'(a) ^ 8'(a >> 8);
      mem1[a] = 8'h00;
    end
    test_reset();
    test_passthrough();
    test_transfer();
    test_random();
    test_restart();
    test_reset_mid();
    test_len1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
